// File: rtl/data_ram_responder_if.sv
// Request/response bus between the memory stage (master) and the data RAM
// responder (slave).
//   ram_ce_in            request valid (chip enable)
//   ram_write_request_in 1 = write, 0 = read
//   ram_addr_in          byte address, bits [1:0] ignored
//   ram_data_in          lane-merged write data
//   ram_data_out         registered read data
//   ram_ready_out        one-cycle response strobe
//   ram_err_out          out-of-range flag, valid with ram_ready_out
//   halt_out             sticky halt flag
interface data_ram_responder_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  ram_ce_in;
    logic                  ram_write_request_in;
    logic [ADDR_WIDTH-1:0] ram_addr_in;
    logic [DATA_WIDTH-1:0] ram_data_in;
    logic [DATA_WIDTH-1:0] ram_data_out;
    logic                  ram_ready_out;
    logic                  ram_err_out;
    logic                  halt_out;

    modport master (
        output ram_ce_in, ram_write_request_in, ram_addr_in, ram_data_in,
        input  ram_data_out, ram_ready_out, ram_err_out, halt_out
    );

    modport slave (
        input  ram_ce_in, ram_write_request_in, ram_addr_in, ram_data_in,
        output ram_data_out, ram_ready_out, ram_err_out, halt_out
    );
endinterface

// File: rtl/data_ram_responder.sv
// Word-wide data RAM responder with configurable wait states and
// out-of-range flagging.
// Ports:
//   clk_in      clock, rising edge
//   reset_n_in  asynchronous reset, active-low
//   bus         data_ram_responder_if.slave (request in, response out)
// Optional feature: define DATA_RAM_HALT_DETECT_EN to build a sticky halt
// detector that fires on any write to HALT_ADDR; otherwise halt_out is 0.
module data_ram_responder #(
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter int unsigned            DATA_WIDTH  = 32,
    parameter int unsigned            DEPTH_WORDS = 4096,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0,
    parameter int unsigned            WAIT_STATES = 1,
    parameter logic [ADDR_WIDTH-1:0]  HALT_ADDR   = ADDR_WIDTH'(32'h0000_FFFC)
) (
    input logic                  clk_in,
    input logic                  reset_n_in,
    data_ram_responder_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  lat_load_c;
    logic                  lat_we_q;
    logic [ADDR_WIDTH-1:0] lat_addr_q;
    logic [DATA_WIDTH-1:0] lat_data_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  ready_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

    // Access operands: latched copy while waiting, live inputs otherwise
    // (the live path is only used for zero-wait-state accesses).
    logic                  accept_c;
    logic                  do_access_c;
    logic                  acc_we_c;
    logic [ADDR_WIDTH-1:0] acc_addr_c;
    logic [DATA_WIDTH-1:0] acc_data_c;
    logic [ADDR_WIDTH-1:0] offset_c;
    logic [IDX_W-1:0]      idx_c;
    logic                  in_range_c;

    assign accept_c    = bus.ram_ce_in && (state_q != ST_WAIT);
    assign acc_we_c    = (state_q == ST_WAIT) ? lat_we_q   : bus.ram_write_request_in;
    assign acc_addr_c  = (state_q == ST_WAIT) ? lat_addr_q : bus.ram_addr_in;
    assign acc_data_c  = (state_q == ST_WAIT) ? lat_data_q : bus.ram_data_in;
    assign do_access_c = ((state_q == ST_WAIT) && (cnt_q == '0)) ||
                         (accept_c && (WAIT_STATES == 0));
    assign offset_c    = acc_addr_c - BASE_ADDR;
    assign idx_c       = offset_c[IDX_W+1:2];
    assign in_range_c  = (acc_addr_c >= BASE_ADDR) &&
                         (offset_c[ADDR_WIDTH-1:2] < (ADDR_WIDTH-2)'(DEPTH_WORDS));

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_load_c = 1'b0;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (bus.ram_ce_in) begin
                    lat_load_c = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_RESP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, latched request and response registers
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            lat_we_q   <= 1'b0;
            lat_addr_q <= '0;
            lat_data_q <= '0;
            data_q     <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == ST_RESP);
            err_q   <= do_access_c && !in_range_c;
            if (lat_load_c) begin
                lat_we_q   <= bus.ram_write_request_in;
                lat_addr_q <= bus.ram_addr_in;
                lat_data_q <= bus.ram_data_in;
            end
            if (do_access_c && !acc_we_c) begin
                data_q <= in_range_c ? mem_q[idx_c] : '0;
            end
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge clk_in) begin
        if (do_access_c && acc_we_c && in_range_c) begin
            mem_q[idx_c] <= acc_data_c;
        end
    end

    assign bus.ram_data_out  = data_q;
    assign bus.ram_ready_out = ready_q;
    assign bus.ram_err_out   = err_q;

`ifdef DATA_RAM_HALT_DETECT_EN
    logic halt_q;

    // Sticky: any write to the halt word, in range or not
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            halt_q <= 1'b0;
        end else if (do_access_c && acc_we_c &&
                     ({acc_addr_c[ADDR_WIDTH-1:2], 2'b00} ==
                      {HALT_ADDR[ADDR_WIDTH-1:2], 2'b00})) begin
            halt_q <= 1'b1;
        end
    end

    assign bus.halt_out = halt_q;

    logic unused_bits;
    assign unused_bits = ^{acc_addr_c[1:0], offset_c[1:0]};
`else
    assign bus.halt_out = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{acc_addr_c[1:0], offset_c[1:0], HALT_ADDR};
`endif

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench for data_ram_responder: one instance with one wait state,
// one with zero wait states, sharing clock and reset.
module tb_data_ram_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    data_ram_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if1 ();
    data_ram_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if0 ();

    data_ram_responder #(.WAIT_STATES(1)) u_dut1 (
        .clk_in     (clk),
        .reset_n_in (rst_n),
        .bus        (if1.slave)
    );

    data_ram_responder #(.WAIT_STATES(0)) u_dut0 (
        .clk_in     (clk),
        .reset_n_in (rst_n),
        .bus        (if0.slave)
    );

    // One complete transaction on the selected instance (sel=1 -> 1 wait state)
    task automatic xfer(input logic sel, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat);
        logic rdy;
        @(negedge clk);
        if (sel) begin
            if1.ram_ce_in = 1'b1; if1.ram_write_request_in = we;
            if1.ram_addr_in = addr; if1.ram_data_in = wdata;
        end else begin
            if0.ram_ce_in = 1'b1; if0.ram_write_request_in = we;
            if0.ram_addr_in = addr; if0.ram_data_in = wdata;
        end
        @(posedge clk);
        lat = 0;
        rdy = 1'b0;
        while (!rdy && lat < 20) begin
            @(negedge clk);
            lat++;
            rdy = sel ? if1.ram_ready_out : if0.ram_ready_out;
        end
        rdata = sel ? if1.ram_data_out : if0.ram_data_out;
        err   = sel ? if1.ram_err_out  : if0.ram_err_out;
        if (sel) if1.ram_ce_in = 1'b0;
        else     if0.ram_ce_in = 1'b0;
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL xfer_timeout addr=%h: no ready within %0d cycles", addr, lat);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({if1.ram_ready_out, if1.ram_err_out, if1.halt_out} !== 3'b000 ||
            if1.ram_data_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_dut1: rdy/err/halt=%b%b%b data=%h, need 000 0",
                     if1.ram_ready_out, if1.ram_err_out, if1.halt_out, if1.ram_data_out);
        end
        checks++;
        if ({if0.ram_ready_out, if0.ram_err_out, if0.halt_out} !== 3'b000 ||
            if0.ram_data_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_dut0: rdy/err/halt=%b%b%b data=%h, need 000 0",
                     if0.ram_ready_out, if0.ram_err_out, if0.halt_out, if0.ram_data_out);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        logic [31:0] d; logic e; int lat;
        xfer(1'b1, 1'b1, 32'h40, 32'h1234_5678, d, e, lat);
        checks++;
        if (lat !== 2 || e !== 1'b0) begin
            errors++;
            $display("FAIL wr_latency: lat=%0d err=%b, need lat=2 err=0", lat, e);
        end
        xfer(1'b1, 1'b0, 32'h40, 32'h0, d, e, lat);
        checks++;
        if (lat !== 2 || e !== 1'b0) begin
            errors++;
            $display("FAIL rd_latency: lat=%0d err=%b, need lat=2 err=0", lat, e);
        end
        checks++;
        if (d !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rd_data: got %h, need 12345678", d);
        end
        @(negedge clk);
        checks++;
        if (if1.ram_ready_out !== 1'b0) begin
            errors++;
            $display("FAIL ready_one_cycle: ready=%b, need 0", if1.ram_ready_out);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d; logic e; int lat;
        xfer(1'b1, 1'b1, 32'h0, 32'hC0DE_0000, d, e, lat);
        xfer(1'b1, 1'b0, 32'h4000, 32'h0, d, e, lat);
        checks++;
        if (e !== 1'b1 || d !== 32'h0) begin
            errors++;
            $display("FAIL oor_read: err=%b data=%h, need err=1 data=0", e, d);
        end
        xfer(1'b1, 1'b1, 32'h4000, 32'hBAD0_BAD0, d, e, lat);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("FAIL oor_write_err: err=%b, need 1", e);
        end
        xfer(1'b1, 1'b0, 32'h0, 32'h0, d, e, lat);
        checks++;
        if (d !== 32'hC0DE_0000 || e !== 1'b0) begin
            errors++;
            $display("FAIL oor_no_alias: word0=%h err=%b, need c0de0000 err=0", d, e);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] d; logic e; int lat;
        xfer(1'b1, 1'b1, 32'h23, 32'hA5A5_A5A5, d, e, lat);
        xfer(1'b1, 1'b0, 32'h20, 32'h0, d, e, lat);
        checks++;
        if (d !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL misaligned: got %h, need a5a5a5a5", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic e; int lat;
        logic [31:0] addrs [3];
        logic [31:0] vals  [3];
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
        vals[0] = 32'h1111_0000; vals[1] = 32'h2222_0004; vals[2] = 32'h3333_0008;
        for (int i = 0; i < 3; i++) xfer(1'b0, 1'b1, addrs[i], vals[i], d, e, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL ws0_latency: lat=%0d, need 1", lat);
        end
        @(negedge clk);
        if0.ram_ce_in = 1'b1; if0.ram_write_request_in = 1'b0; if0.ram_addr_in = addrs[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (if0.ram_ready_out !== 1'b1 || if0.ram_data_out !== vals[i] ||
                if0.ram_err_out !== 1'b0) begin
                errors++;
                $display("FAIL b2b_%0d: rdy=%b err=%b data=%h, need 1 0 %h", i,
                         if0.ram_ready_out, if0.ram_err_out, if0.ram_data_out, vals[i]);
            end
            if (i < 2) if0.ram_addr_in = addrs[i+1];
            else       if0.ram_ce_in = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (if0.ram_ready_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: ready=%b, need 0", if0.ram_ready_out);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] d; logic e; int lat;
        xfer(1'b1, 1'b1, 32'h10, 32'h1111_1111, d, e, lat);
        xfer(1'b1, 1'b0, 32'h10, 32'h0, d, e, lat);
        @(negedge clk);
        if1.ram_ce_in = 1'b1; if1.ram_write_request_in = 1'b1;
        if1.ram_addr_in = 32'h10; if1.ram_data_in = 32'hDEAD_BEEF;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({if1.ram_ready_out, if1.ram_err_out, if1.halt_out} !== 3'b000 ||
            if1.ram_data_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_wait: rdy/err/halt=%b%b%b data=%h, need 000 0",
                     if1.ram_ready_out, if1.ram_err_out, if1.halt_out, if1.ram_data_out);
        end
        @(negedge clk);
        if1.ram_ce_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b1, 1'b0, 32'h10, 32'h0, d, e, lat);
        checks++;
        if (d !== 32'h1111_1111) begin
            errors++;
            $display("FAIL reset_drop_write: got %h, need 11111111", d);
        end
    endtask

    task automatic test_halt();
        logic [31:0] d; logic e; int lat;
`ifdef DATA_RAM_HALT_DETECT_EN
        xfer(1'b1, 1'b1, 32'hFFFC, 32'h0000_0001, d, e, lat);
        checks++;
        if (if1.halt_out !== 1'b1) begin
            errors++;
            $display("FAIL halt_set: halt=%b, need 1", if1.halt_out);
        end
        xfer(1'b1, 1'b0, 32'h40, 32'h0, d, e, lat);
        checks++;
        if (if1.halt_out !== 1'b1) begin
            errors++;
            $display("FAIL halt_sticky: halt=%b, need 1", if1.halt_out);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (if1.halt_out !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset: halt=%b, need 0", if1.halt_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
`else
        xfer(1'b1, 1'b1, 32'hFFFC, 32'h0000_0001, d, e, lat);
        checks++;
        if (if1.halt_out !== 1'b0) begin
            errors++;
            $display("FAIL halt_disabled: halt=%b, need 0", if1.halt_out);
        end
`endif
    endtask

    initial begin
        if1.ram_ce_in = 1'b0; if1.ram_write_request_in = 1'b0;
        if1.ram_addr_in = '0; if1.ram_data_in = '0;
        if0.ram_ce_in = 1'b0; if0.ram_write_request_in = 1'b0;
        if0.ram_addr_in = '0; if0.ram_data_in = '0;
        test_reset();
        test_write_read();
        test_out_of_range();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_wait();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
